lfsr_seq_ctrl: RTL and testbench

// Command-driven sequencer wrapped around a WIDTH-bit Fibonacci LFSR. Accepts
// one command (taps, seed, word count), streams LFSR states out over a

---
 rtl/lfsr_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: command-driven sequencer around a WIDTH-bit Fibonacci LFSR.
// One command (taps, seed, word count) produces a stream of LFSR states on a
// valid/ready interface; the LFSR stalls under back-pressure.
// Optional feature macro: PERIOD_CHECK_EN adds period / period_valid outputs
// reporting the first return of the LFSR to its start state.
module lfsr_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_taps,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
`ifdef PERIOD_CHECK_EN
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
`endif
  output logic             seed_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] SeedOne = WIDTH'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           st_q, st_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             seed_err_q, seed_err_d;
  logic [WIDTH-1:0] lfsr_nxt;
  logic             xfer;
  logic             last_word;

`ifdef PERIOD_CHECK_EN
  logic [WIDTH-1:0] start_q, start_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
`endif

  // LFSR step: parity of tapped bits shifted in at the LSB.
  assign lfsr_nxt  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & taps_q)};
  assign last_word = (st_q == StRun) && (count_q != '0) && (counter_q == count_q - CntOne);
  assign xfer      = out_valid && out_ready;

  // Combinational outputs; abort masks out_valid in the same cycle.
  always_comb begin
    cmd_ready = (st_q == StIdle);
    out_valid = (st_q == StRun) && !abort;
    out_data  = lfsr_q;
    out_last  = last_word;
    busy      = (st_q == StRun) || (st_q == StDone);
    done      = (st_q == StDone);
    seed_err  = seed_err_q;
`ifdef PERIOD_CHECK_EN
    period       = period_q;
    period_valid = period_valid_q;
`endif
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    st_d       = st_q;
    lfsr_d     = lfsr_q;
    taps_d     = taps_q;
    count_d    = count_q;
    counter_d  = counter_q;
    seed_err_d = seed_err_q;
`ifdef PERIOD_CHECK_EN
    start_d        = start_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
`endif
    unique case (st_q)
      StIdle: begin
        if (cmd_valid) begin
          taps_d    = cmd_taps;
          count_d   = cmd_count;
          counter_d = '0;
          // An all-zero seed would lock the LFSR, so substitute 1 and flag it.
          if (cmd_seed == '0) begin
            lfsr_d     = SeedOne;
            seed_err_d = 1'b1;
          end else begin
            lfsr_d     = cmd_seed;
            seed_err_d = 1'b0;
          end
`ifdef PERIOD_CHECK_EN
          start_d        = lfsr_d;
          period_d       = '0;
          period_valid_d = 1'b0;
`endif
          st_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          st_d = StDone;
        end else if (xfer) begin
          lfsr_d    = lfsr_nxt;
          counter_d = counter_q + CntOne;
`ifdef PERIOD_CHECK_EN
          if (!period_valid_q && (lfsr_nxt == start_q)) begin
            period_d       = counter_q + CntOne;
            period_valid_d = 1'b1;
          end
`endif
          if (last_word) st_d = StDone;
        end
      end
      StDone: begin
        st_d = StIdle;
      end
      default: begin
        st_d = StIdle;
      end
    endcase
  end

  // State registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= StIdle;
      lfsr_q     <= '0;
      taps_q     <= '0;
      count_q    <= '0;
      counter_q  <= '0;
      seed_err_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      lfsr_q     <= lfsr_d;
      taps_q     <= taps_d;
      count_q    <= count_d;
      counter_q  <= counter_d;
      seed_err_q <= seed_err_d;
    end
  end

`ifdef PERIOD_CHECK_EN
  // Period-detection registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      start_q        <= start_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed testbench for lfsr_seq_ctrl (taps 8E sequence hand-derived).
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_taps = '0;
  logic [7:0]  cmd_seed = '0;
  logic [15:0] cmd_count = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        seed_err;
`ifdef PERIOD_CHECK_EN
  logic [15:0] period;
  logic        period_valid;
`endif

  int total = 0;
  int bad   = 0;

  // Taps 8E from seed 01, worked by hand.
  logic [7:0] exp_seq [0:10] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C,
                                 8'h58, 8'hB1, 8'h63, 8'hC7, 8'h8F};

  lfsr_seq_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_taps     (cmd_taps),
    .cmd_seed     (cmd_seed),
    .cmd_count    (cmd_count),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
`ifdef PERIOD_CHECK_EN
    .period       (period),
    .period_valid (period_valid),
`endif
    .seed_err     (seed_err)
  );

  always #5 clk = ~clk;

  // Present a command for one cycle; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] taps, input logic [7:0] seed, input logic [15:0] cnt);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_taps = taps; cmd_seed = seed; cmd_count = cnt;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL send_cmd_ready got=%b want=1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({out_valid, out_last, busy, done, seed_err, cmd_ready} !== 6'b000001 || out_data !== 8'h00)
    begin
      bad++;
      $display("FAIL reset_outputs got=%b data=%h want=000001 data=00",
               {out_valid, out_last, busy, done, seed_err, cmd_ready}, out_data);
    end
`ifdef PERIOD_CHECK_EN
    total++;
    if (period !== 16'd0 || period_valid !== 1'b0) begin
      bad++; $display("FAIL reset_period got=%0d/%b want=0/0", period, period_valid);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send(8'h8E, 8'h01, 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i] || out_last !== (i == 3) || busy !== 1'b1)
      begin
        bad++;
        $display("FAIL basic_word%0d got=%b/%h/%b want=1/%h/%b", i, out_valid, out_data,
                 out_last, exp_seq[i], (i == 3));
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL basic_done got=%b%b%b%b want=1010", done, out_valid, busy, cmd_ready);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle got=%b%b%b want=010", done, cmd_ready, busy);
    end
  endtask

  // Stall on the third word; a foreign command presented meanwhile is ignored.
  task automatic test_back_pressure();
    send(8'h8E, 8'h01, 16'd4);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_data !== exp_seq[i]) begin
        bad++; $display("FAIL bp_word%0d got=%h want=%h", i, out_data, exp_seq[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_seed = 8'h77; cmd_count = 16'd1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h05 || out_last !== 1'b0 || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall%0d got=%b/%h/%b/%b want=1/05/0/0", i, out_valid, out_data,
                 out_last, cmd_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    cmd_valid = 1'b0;
    total++;
    if (out_data !== 8'h05) begin
      bad++; $display("FAIL bp_release got=%h want=05", out_data);
    end
    @(negedge clk);
    total++;
    if (out_data !== 8'h0B || out_last !== 1'b1) begin
      bad++; $display("FAIL bp_last got=%h/%b want=0B/1", out_data, out_last);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL bp_done got=%b want=1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_seed_err();
    send(8'h8E, 8'h00, 16'd2);
    total++;
    if (seed_err !== 1'b1 || out_data !== 8'h01 || out_last !== 1'b0) begin
      bad++; $display("FAIL seed0_word0 got=%b/%h/%b want=1/01/0", seed_err, out_data, out_last);
    end
    @(negedge clk);
    total++;
    if (out_data !== 8'h02 || out_last !== 1'b1) begin
      bad++; $display("FAIL seed0_word1 got=%h/%b want=02/1", out_data, out_last);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (seed_err !== 1'b1 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL seed_err_sticky got=%b/%b want=1/1", seed_err, cmd_ready);
    end
    send(8'h8E, 8'h01, 16'd1);
    total++;
    if (seed_err !== 1'b0 || out_data !== 8'h01 || out_last !== 1'b1) begin
      bad++; $display("FAIL seed_err_clear got=%b/%h/%b want=0/01/1", seed_err, out_data, out_last);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_abort();
    send(8'h8E, 8'h01, 16'd0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i] || out_last !== 1'b0) begin
        bad++;
        $display("FAIL free_word%0d got=%b/%h/%b want=1/%h/0", i, out_valid, out_data, out_last,
                 exp_seq[i]);
      end
      @(negedge clk);
    end
    abort = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== exp_seq[10] || busy !== 1'b1 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL abort_mask got=%b/%h/%b/%b want=0/%h/1/0", out_valid, out_data, busy,
               out_last, exp_seq[10]);
    end
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL abort_done got=%b/%b/%b want=1/0/0", done, out_valid, out_last);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=%b/%b want=1/0", cmd_ready, done);
    end
  endtask

`ifdef PERIOD_CHECK_EN
  task automatic test_period();
    logic [7:0] exp;
    logic       seen [0:255];
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    exp = 8'h01;
    send(8'h8E, 8'h01, 16'd300);
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp || out_last !== (i == 299)) begin
        bad++; $display("FAIL period_word%0d got=%h/%b want=%h", i, out_data, out_last, exp);
      end
      if (i < 255) begin
        total++;
        if (seen[out_data] !== 1'b0 || out_data === 8'h00) begin
          bad++; $display("FAIL period_repeat%0d got=%h want=fresh nonzero", i, out_data);
        end
        seen[out_data] = 1'b1;
      end
      total++;
      if (period_valid !== (i >= 255) || (i >= 255 && period !== 16'd255)) begin
        bad++;
        $display("FAIL period_val%0d got=%0d/%b want=255/%b", i, period, period_valid, (i >= 255));
      end
      exp = {exp[6:0], ^(exp & 8'h8E)};
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || period !== 16'd255) begin
      bad++; $display("FAIL period_done got=%b/%0d want=1/255", done, period);
    end
    @(negedge clk);
    send(8'h8E, 8'h01, 16'd1);
    total++;
    if (period_valid !== 1'b0 || period !== 16'd0) begin
      bad++; $display("FAIL period_clear got=%0d/%b want=0/0", period, period_valid);
    end
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_midrun();
    send(8'h8E, 8'h00, 16'd10);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_data !== exp_seq[i] || seed_err !== 1'b1) begin
        bad++; $display("FAIL mid_word%0d got=%h/%b want=%h/1", i, out_data, seed_err, exp_seq[i]);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_last, busy, done, seed_err, cmd_ready} !== 6'b000001 || out_data !== 8'h00)
    begin
      bad++;
      $display("FAIL mid_reset got=%b data=%h want=000001 data=00",
               {out_valid, out_last, busy, done, seed_err, cmd_ready}, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL mid_nodone%0d got=%b/%b want=0/0", i, done, busy);
      end
      @(negedge clk);
    end
    send(8'h8E, 8'h05, 16'd3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i+2] || out_last !== (i == 2)) begin
        bad++;
        $display("FAIL restart_word%0d got=%h/%b want=%h/%b", i, out_data, out_last,
                 exp_seq[i+2], (i == 2));
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL restart_done got=%b want=1", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_seed_err();
    test_abort();
`ifdef PERIOD_CHECK_EN
    test_period();
`endif
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
